// File: rtl/legv8_instr_encoder.sv
// legv8_instr_encoder
// Packs an opcode, register fields and a 64-bit immediate or branch target into
// a 32-bit LEGv8 instruction word. Branch formats encode the word offset from
// pc to the target. Out-of-range, misaligned or unknown-format requests come
// back with err=1 and a zero word, and are tallied in a saturating counter.
// One request is in flight at a time: IDLE -> CALC -> CHECK -> OUT.

module legv8_instr_encoder #(
   parameter int ERRW = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [4:0]      imm_op,
   input  logic [10:0]     opcode,
   input  logic [4:0]      rd_rt,
   input  logic [4:0]      rn,
   input  logic [4:0]      rm,
   input  logic [63:0]     pc,
   input  logic [63:0]     value,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [31:0]     instr,
   output logic            err,
   output logic [ERRW-1:0] err_count
);

   // format selectors, matching the decode-side immediate extractor
   localparam logic [4:0] IMMOP_B     = 5'd1;
   localparam logic [4:0] IMMOP_CB    = 5'd2;
   localparam logic [4:0] IMMOP_I     = 5'd3;
   localparam logic [4:0] IMMOP_SHIFT = 5'd4;
   localparam logic [4:0] IMMOP_D     = 5'd5;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_CALC  = 2'd1;
   localparam logic [1:0] S_CHECK = 2'd2;
   localparam logic [1:0] S_OUT   = 2'd3;

   logic [1:0]      state;
   logic [4:0]      op_q;
   logic [10:0]     opc_q;
   logic [4:0]      rd_q;
   logic [4:0]      rn_q;
   logic [4:0]      rm_q;
   logic [63:0]     pc_q;
   logic [63:0]     val_q;
   logic [63:0]     imm_q;
   logic [31:0]     instr_q;
   logic            err_q;
   logic [ERRW-1:0] cnt_q;

   logic [31:0]     enc;
   logic            bad;

   assign in_ready  = (state == S_IDLE);
   assign out_valid = (state == S_OUT);
   assign instr     = instr_q;
   assign err       = err_q;
   assign err_count = cnt_q;

   // Encode the word and decide whether the immediate fits its field; the
   // range test looks at all 64 bits, so upper bits must be pure sign or zero
   always_comb begin
      enc = 32'h0;
      bad = 1'b1;
      case (op_q)
         IMMOP_B: begin
            enc = {opc_q[10:5], imm_q[27:2]};
            bad = (imm_q[1:0] != 2'b00) || (imm_q[63:27] != {37{imm_q[27]}});
         end
         IMMOP_CB: begin
            enc = {opc_q[10:3], imm_q[20:2], rd_q};
            bad = (imm_q[1:0] != 2'b00) || (imm_q[63:20] != {44{imm_q[20]}});
         end
         IMMOP_I: begin
            enc = {opc_q[10:1], imm_q[11:0], rn_q, rd_q};
            bad = (imm_q[63:12] != 52'd0);
         end
         IMMOP_SHIFT: begin
            enc = {opc_q, rm_q, imm_q[5:0], rn_q, rd_q};
            bad = (imm_q[63:6] != 58'd0);
         end
         IMMOP_D: begin
            enc = {opc_q, imm_q[8:0], 2'b00, rn_q, rd_q};
            bad = (imm_q[63:8] != {56{imm_q[8]}});
         end
         default: begin
            enc = 32'h0;
            bad = 1'b1;
         end
      endcase
   end

   // Request sequencing: capture in IDLE, form the offset in CALC, register
   // the result in CHECK, then hold it in OUT until the consumer takes it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_IDLE;
         op_q    <= 5'd0;
         opc_q   <= 11'd0;
         rd_q    <= 5'd0;
         rn_q    <= 5'd0;
         rm_q    <= 5'd0;
         pc_q    <= 64'd0;
         val_q   <= 64'd0;
         imm_q   <= 64'd0;
         instr_q <= 32'h0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  op_q  <= imm_op;
                  opc_q <= opcode;
                  rd_q  <= rd_rt;
                  rn_q  <= rn;
                  rm_q  <= rm;
                  pc_q  <= pc;
                  val_q <= value;
                  state <= S_CALC;
               end
            end
            S_CALC: begin
               if (op_q == IMMOP_B || op_q == IMMOP_CB)
                  imm_q <= val_q - pc_q;
               else
                  imm_q <= val_q;
               state <= S_CHECK;
            end
            S_CHECK: begin
               instr_q <= bad ? 32'h0 : enc;
               err_q   <= bad;
               if (bad && (cnt_q != {ERRW{1'b1}}))
                  cnt_q <= cnt_q + ERRW'(1);
               state <= S_OUT;
            end
            default: begin
               if (out_ready)
                  state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
